// File: rtl/rotary_encoder_frontend.sv
// rotary_encoder_frontend
//   Turns raw rotary-encoder contacts into clean single-cycle events for the
//   BCD counter stage. Each contact is synchronised (2 flops), debounced
//   independently, then quadrature A/B is decoded into one event per detent
//   and the push switch D into one event per press.
//
// Ports
//   clk_in       in   system clock
//   rst_n_in     in   asynchronous, active-low reset
//   key_a        in   raw encoder channel A (idle high)
//   key_b        in   raw encoder channel B (idle high)
//   key_d        in   raw push switch (pressed = 0)
//   Right_pulse  out  one-cycle pulse per clockwise detent
//   Left_pulse   out  one-cycle pulse per counter-clockwise detent
//   d_pulse      out  one-cycle pulse per debounced press of key_d
module rotary_encoder_frontend #(
  parameter int DEBOUNCE_CYCLES  = 12000,
  parameter int STEPS_PER_DETENT = 4
) (
  input  logic clk_in,
  input  logic rst_n_in,
  input  logic key_a,
  input  logic key_b,
  input  logic key_d,
  output logic Right_pulse,
  output logic Left_pulse,
  output logic d_pulse
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic signed [3:0] DETENT_POS = 4'(STEPS_PER_DETENT);
  localparam logic signed [3:0] DETENT_NEG = 4'(-STEPS_PER_DETENT);

  // Bit order for the per-contact vectors: [2] = A, [1] = B, [0] = D.
  logic [2:0]    raw;
  logic [2:0]    s1_q, s2_q;
  logic [2:0]    stable_q, stable_d;
  logic [CW-1:0] cnt_q [3];
  logic [CW-1:0] cnt_d [3];

  logic [1:0]        ab_prev_q;
  logic [1:0]        ab_cur;
  logic              d_prev_q;
  logic signed [3:0] acc_q, acc_d;
  logic signed [3:0] step;
  logic signed [3:0] nxt;
  logic              illegal;
  logic              right_q, right_d;
  logic              left_q, left_d;
  logic              dp_q, dp_d;

  assign raw = {key_a, key_b, key_d};

  // Debounce: a contact must differ from its stable value for
  // DEBOUNCE_CYCLES consecutive cycles; any return to stable restarts it.
  always_comb begin
    stable_d = stable_q;
    for (int i = 0; i < 3; i++) begin
      cnt_d[i] = '0;
      if (s2_q[i] != stable_q[i]) begin
        if (cnt_q[i] == CNT_LAST) begin
          stable_d[i] = s2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CW'(1);
        end
      end
    end
  end

  assign ab_cur = stable_q[2:1];

  // Clockwise {A,B}: 11 -> 01 -> 00 -> 10 -> 11.
  always_comb begin
    step    = 4'sd0;
    illegal = ((ab_prev_q ^ ab_cur) == 2'b11);
    case ({ab_prev_q, ab_cur})
      4'b11_01, 4'b01_00, 4'b00_10, 4'b10_11: step = 4'sd1;
      4'b01_11, 4'b00_01, 4'b10_00, 4'b11_10: step = -4'sd1;
      default:                                step = 4'sd0;
    endcase
  end

  assign nxt = acc_q + step;

  always_comb begin
    acc_d   = acc_q;
    right_d = 1'b0;
    left_d  = 1'b0;
    if (!illegal) begin
      if (nxt == DETENT_POS) begin
        right_d = 1'b1;
        acc_d   = 4'sd0;
      end else if (nxt == DETENT_NEG) begin
        left_d = 1'b1;
        acc_d  = 4'sd0;
      end else if (ab_cur == 2'b11) begin
        // Resting at a detent: drop any partial count so lost steps
        // cannot accumulate across detents.
        acc_d = 4'sd0;
      end else begin
        acc_d = nxt;
      end
    end
  end

  // Press is the stable 1 -> 0 edge only; release and hold are silent.
  assign dp_d = d_prev_q & ~stable_q[0];

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      s1_q      <= 3'b111;
      s2_q      <= 3'b111;
      stable_q  <= 3'b111;
      for (int i = 0; i < 3; i++) cnt_q[i] <= '0;
      ab_prev_q <= 2'b11;
      d_prev_q  <= 1'b1;
      acc_q     <= 4'sd0;
      right_q   <= 1'b0;
      left_q    <= 1'b0;
      dp_q      <= 1'b0;
    end else begin
      s1_q      <= raw;
      s2_q      <= s1_q;
      stable_q  <= stable_d;
      for (int i = 0; i < 3; i++) cnt_q[i] <= cnt_d[i];
      ab_prev_q <= ab_cur;
      d_prev_q  <= stable_q[0];
      acc_q     <= acc_d;
      right_q   <= right_d;
      left_q    <= left_d;
      dp_q      <= dp_d;
    end
  end

  assign Right_pulse = right_q;
  assign Left_pulse  = left_q;
  assign d_pulse     = dp_q;

endmodule

// File: tb/tb_rotary_encoder_frontend.sv
// Directed bench for rotary_encoder_frontend with DEBOUNCE_CYCLES=4,
// STEPS_PER_DETENT=4. Expected pulse counts and latencies are hand-derived:
// a change applied just after edge k is seen as a pulse after edge k+7.
module tb_rotary_encoder_frontend;

  logic clk_in = 1'b0;
  logic rst_n_in;
  logic key_a, key_b, key_d;
  logic Right_pulse, Left_pulse, d_pulse;

  int checks   = 0;
  int failures = 0;

  int cyc = 0;
  int r_cnt = 0, l_cnt = 0, d_cnt = 0;
  int r_cyc = 0, l_cyc = 0, d_cyc = 0;
  int wide_cnt = 0, both_cnt = 0;
  logic r_prev = 1'b0, l_prev = 1'b0, d_prev = 1'b0;
  int t_apply;
  int r0, l0, d0;

  rotary_encoder_frontend #(
    .DEBOUNCE_CYCLES (4),
    .STEPS_PER_DETENT(4)
  ) dut (
    .clk_in     (clk_in),
    .rst_n_in   (rst_n_in),
    .key_a      (key_a),
    .key_b      (key_b),
    .key_d      (key_d),
    .Right_pulse(Right_pulse),
    .Left_pulse (Left_pulse),
    .d_pulse    (d_pulse)
  );

  always #5 clk_in = ~clk_in;

  always @(posedge clk_in) cyc <= cyc + 1;

  always @(negedge clk_in) begin
    if (Right_pulse) begin
      r_cnt <= r_cnt + 1;
      r_cyc <= cyc;
    end
    if (Left_pulse) begin
      l_cnt <= l_cnt + 1;
      l_cyc <= cyc;
    end
    if (d_pulse) begin
      d_cnt <= d_cnt + 1;
      d_cyc <= cyc;
    end
    if ((Right_pulse && r_prev) || (Left_pulse && l_prev) || (d_pulse && d_prev))
      wide_cnt <= wide_cnt + 1;
    if (Right_pulse && Left_pulse) both_cnt <= both_cnt + 1;
    r_prev <= Right_pulse;
    l_prev <= Left_pulse;
    d_prev <= d_pulse;
  end

  task automatic check_eq(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic hold(input int n);
    repeat (n) begin
      @(posedge clk_in);
      #1;
    end
  endtask

  task automatic apply_ab(input logic a, input logic b, input int n);
    key_a   = a;
    key_b   = b;
    t_apply = cyc;
    hold(n);
  endtask

  task automatic detent_cw(input int n);
    apply_ab(1'b0, 1'b1, n);
    apply_ab(1'b0, 1'b0, n);
    apply_ab(1'b1, 1'b0, n);
    apply_ab(1'b1, 1'b1, n);
  endtask

  task automatic detent_ccw(input int n);
    apply_ab(1'b1, 1'b0, n);
    apply_ab(1'b0, 1'b0, n);
    apply_ab(1'b0, 1'b1, n);
    apply_ab(1'b1, 1'b1, n);
  endtask

  task automatic snap();
    r0 = r_cnt;
    l0 = l_cnt;
    d0 = d_cnt;
  endtask

  initial begin
    key_a    = 1'b1;
    key_b    = 1'b1;
    key_d    = 1'b1;
    rst_n_in = 1'b0;

    // 1. reset with idle keys
    hold(20);
    check_eq("rst_right", int'(Right_pulse), 0);
    check_eq("rst_left", int'(Left_pulse), 0);
    check_eq("rst_d", int'(d_pulse), 0);
    rst_n_in = 1'b1;
    hold(50);
    check_eq("idle_pulses", r_cnt + l_cnt + d_cnt, 0);

    // 2. clean clockwise detent
    snap();
    detent_cw(10);
    check_eq("cw_right", r_cnt - r0, 1);
    check_eq("cw_left", l_cnt - l0, 0);
    check_eq("cw_latency", r_cyc - t_apply, 7);

    // 3. counter-clockwise detent, then five clockwise
    snap();
    detent_ccw(10);
    check_eq("ccw_left", l_cnt - l0, 1);
    check_eq("ccw_right", r_cnt - r0, 0);
    check_eq("ccw_latency", l_cyc - t_apply, 7);
    snap();
    repeat (5) detent_cw(10);
    check_eq("cw5_right", r_cnt - r0, 5);
    check_eq("cw5_left", l_cnt - l0, 0);

    // 4. fast chatter on A never accepted
    snap();
    for (int i = 0; i < 20; i++) begin
      key_a = ~key_a;
      hold(2);
    end
    key_a = 1'b1;
    hold(20);
    check_eq("chatter_pulses", (r_cnt - r0) + (l_cnt - l0) + (d_cnt - d0), 0);
    snap();
    detent_cw(10);
    check_eq("after_chatter_cw", r_cnt - r0, 1);

    // 5. bouncy press, long hold, release
    snap();
    for (int i = 0; i < 3; i++) begin
      key_d = 1'b0;
      hold(2);
      key_d = 1'b1;
      hold(2);
    end
    key_d   = 1'b0;
    t_apply = cyc;
    hold(100);
    check_eq("press_count", d_cnt - d0, 1);
    check_eq("press_latency", d_cyc - t_apply, 7);
    key_d = 1'b1;
    hold(30);
    check_eq("release_count", d_cnt - d0, 1);
    check_eq("press_no_rot", (r_cnt - r0) + (l_cnt - l0), 0);

    // 6a. half detent returns to rest without an event
    snap();
    apply_ab(1'b0, 1'b1, 10);
    apply_ab(1'b0, 1'b0, 10);
    apply_ab(1'b0, 1'b1, 10);
    apply_ab(1'b1, 1'b1, 10);
    check_eq("half_pulses", (r_cnt - r0) + (l_cnt - l0), 0);
    snap();
    detent_cw(10);
    check_eq("half_then_cw", r_cnt - r0, 1);

    // 6b. reset at 00 mid-detent, then finish the sequence
    snap();
    apply_ab(1'b0, 1'b1, 10);
    apply_ab(1'b0, 1'b0, 10);
    rst_n_in = 1'b0;
    hold(3);
    rst_n_in = 1'b1;
    hold(2);
    check_eq("rst_exit_quiet", int'(Right_pulse) + int'(Left_pulse) + int'(d_pulse), 0);
    hold(10);
    apply_ab(1'b1, 1'b0, 10);
    apply_ab(1'b1, 1'b1, 10);
    check_eq("midrst_right", r_cnt - r0, 0);
    check_eq("midrst_left", l_cnt - l0, 0);
    snap();
    detent_cw(10);
    check_eq("midrst_then_cw", r_cnt - r0, 1);

    check_eq("pulse_width", wide_cnt, 0);
    check_eq("right_left_overlap", both_cnt, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
